// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder: two half adders and an OR for the carry.
module serial_fa_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic cin_i,
  output logic s_o,
  output logic co_o
);

  logic ha0_s, ha0_c, ha1_c;

  assign ha0_s = x_i ^ y_i;
  assign ha0_c = x_i & y_i;
  assign s_o   = ha0_s ^ cin_i;
  assign ha1_c = ha0_s & cin_i;
  assign co_o  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder, LSB first, sharing one full-adder cell.
// Define SERIAL_ADD_SUB_EN to add a sub_i port for a - b.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ena_i,
  input  logic             start_i,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
  logic             sub;

`ifdef SERIAL_ADD_SUB_EN
  assign sub = sub_i;
`else
  assign sub = 1'b0;
`endif

  serial_fa_cell u_fa (
    .x_i   (a_sr_q[0]),
    .y_i   (b_sr_q[0]),
    .cin_i (carry_q),
    .s_o   (fa_s),
    .co_o  (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (ena_i) begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            // Subtraction is a + ~b + 1: invert b on load and seed the carry.
            a_sr_d  = a_i;
            b_sr_d  = sub ? ~b_i : b_i;
            carry_d = sub;
            cnt_d   = '0;
            sum_d   = '0;
            state_d = StRun;
          end else if (state_q == StDone) begin
            state_d = StIdle;
          end
        end
        StRun: begin
          sum_d   = {fa_s, sum_q[WIDTH-1:1]};
          carry_d = fa_co;
          a_sr_d  = a_sr_q >> 1;
          b_sr_d  = b_sr_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CntLast) begin
            state_d = StDone;
            cout_d  = fa_co;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule
